// File: rtl/axil_reg_slave_pkg.sv
// Shared AXI4-lite definitions for the axil_* responders: response codes
// and the address-to-register-index helper.
package axil_reg_slave_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Word index of an address: bits above the byte lane, below addr_width.
    function automatic logic [31:0] axil_addr_idx(
        input logic [63:0]  addr,
        input int unsigned  addr_width,
        input int unsigned  lsb
    );
        logic [63:0] masked;
        masked = addr & ((64'd1 << addr_width) - 64'd1);
        return 32'(masked >> lsb);
    endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-lite responder terminating a crossbar port in a bank of memory-mapped
// registers, with read-only hardware inputs and per-register access strobes.
module axil_reg_slave
    import axil_reg_slave_pkg::*;
#(
    parameter int                              DATA_WIDTH  = 32,
    parameter int                              ADDR_WIDTH  = 16,
    parameter int                              STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int                              REG_COUNT   = 16,
    parameter logic [REG_COUNT-1:0]            RO_MASK     = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,

    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,

    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,

    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,

    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_in,
    output logic [REG_COUNT-1:0]            reg_wr_stb,
    output logic [REG_COUNT-1:0]            reg_rd_stb
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int SEL_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [DATA_WIDTH-1:0] regs    [REG_COUNT];
    logic [DATA_WIDTH-1:0] rd_view [REG_COUNT];

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_WIDTH-1:0] w_strb_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_commit;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [31:0]           wr_idx;
    logic [31:0]           rd_idx;
    logic [SEL_W-1:0]      wr_sel;
    logic [SEL_W-1:0]      rd_sel;
    axi_resp_e             wr_resp;
    axi_resp_e             rd_resp;
    logic                  unused_sink;

    // Readies depend only on internal state, never on incoming valids.
    assign s_axil_awready = !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = !w_held  && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign aw_hs     = s_axil_awvalid && s_axil_awready;
    assign w_hs      = s_axil_wvalid  && s_axil_wready;
    assign ar_hs     = s_axil_arvalid && s_axil_arready;
    assign wr_commit = aw_held && w_held && !s_axil_bvalid;
    assign wr_ok     = (wr_resp == RESP_OKAY);
    assign rd_ok     = (rd_resp == RESP_OKAY);

    assign unused_sink = ^{s_axil_awprot, s_axil_arprot, hw_in};

    always_comb begin
        wr_idx  = axil_addr_idx(64'(aw_addr_reg), ADDR_WIDTH, ADDR_LSB);
        wr_sel  = wr_idx[SEL_W-1:0];
        wr_resp = RESP_OKAY;
        if (wr_idx >= 32'(REG_COUNT)) begin
            wr_resp = RESP_DECERR;
        end else if (RO_MASK[wr_sel]) begin
            wr_resp = RESP_SLVERR;
        end
    end

    // Reads of RO slots are always OKAY; only out-of-range indices fail.
    always_comb begin
        rd_idx  = axil_addr_idx(64'(s_axil_araddr), ADDR_WIDTH, ADDR_LSB);
        rd_sel  = rd_idx[SEL_W-1:0];
        rd_resp = RESP_OKAY;
        if (rd_idx >= 32'(REG_COUNT)) begin
            rd_resp = RESP_DECERR;
        end
    end

    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_slot
            if (RO_MASK[gi]) begin : g_ro
                assign rd_view[gi]                             = hw_in[gi*DATA_WIDTH +: DATA_WIDTH];
                assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH]    = '0;
            end else begin : g_rw
                assign rd_view[gi]                             = regs[gi];
                assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH]    = regs[gi];
            end
        end
    endgenerate

    // Write channel: AW and W latch independently; the transaction commits
    // once both are held and stays parked until the B handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_reg   <= '0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            reg_wr_stb    <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (aw_hs) begin
                aw_held     <= 1'b1;
                aw_addr_reg <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_held     <= 1'b1;
                w_data_reg <= s_axil_wdata;
                w_strb_reg <= s_axil_wstrb;
            end
            if (wr_commit) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_resp;
                if (wr_ok) begin
                    reg_wr_stb[wr_sel] <= 1'b1;
                end
            end
            if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
            end
        end
    end

    // Read channel: data is captured on the AR handshake edge, so a write
    // committing on the same edge is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rdata  <= '0;
            reg_rd_stb    <= '0;
        end else begin
            reg_rd_stb <= '0;
            if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
            if (ar_hs) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rresp  <= rd_resp;
                s_axil_rdata  <= rd_ok ? rd_view[rd_sel] : '0;
                if (rd_ok) begin
                    reg_rd_stb[rd_sel] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= RO_MASK[i] ? '0 : RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (wr_commit && wr_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb_reg[b]) begin
                    regs[wr_sel][b*8 +: 8] <= w_data_reg[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: write/read paths, decode errors,
// byte strobes, handshake skew, backpressure and mid-flight reset.
module tb_axil_reg_slave;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;
    localparam int RC = 16;
    localparam logic [RC-1:0]    RO = 16'h8000;
    localparam logic [RC*DW-1:0] RV = {{(RC*DW-32){1'b0}}, 32'h0000_BEEF} << (3 * DW);
    localparam logic [31:0]      HW15 = 32'h5A5A_0F0F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [RC*DW-1:0] reg_out;
    logic [RC*DW-1:0] hw_in = '0;
    logic [RC-1:0] reg_wr_stb;
    logic [RC-1:0] reg_rd_stb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STRB_WIDTH (SW),
        .REG_COUNT  (RC),
        .RO_MASK    (RO),
        .RESET_VALUE(RV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axil_awaddr (awaddr),
        .s_axil_awprot (3'b000),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .s_axil_araddr (araddr),
        .s_axil_arprot (3'b000),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rvalid (rvalid),
        .s_axil_rready (rready),
        .reg_out       (reg_out),
        .hw_in         (hw_in),
        .reg_wr_stb    (reg_wr_stb),
        .reg_rd_stb    (reg_rd_stb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue AW and W together; returns response, write strobe seen with bvalid,
    // and cycles from the later handshake to bvalid.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            output logic [1:0] resp, output logic [RC-1:0] stb, output int lat);
        bit aw_fire, w_fire;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 50) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
            n++;
        end
        lat = 0;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        if (!bvalid) check("write_timeout", 64'd1, 64'd0);
        resp = bresp;
        stb  = reg_wr_stb;
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp, output logic [RC-1:0] stb);
        bit fire;
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (arvalid && n < 50) begin
            fire = arready;
            tick();
            if (fire) arvalid = 1'b0;
            n++;
        end
        if (!rvalid) check("read_timeout", 64'd1, 64'd0);
        arvalid = 1'b0;
        d = rdata; resp = rresp; stb = reg_rd_stb;
        tick();
    endtask

    initial begin
        logic [1:0]    resp;
        logic [RC-1:0] stb;
        logic [DW-1:0] d;
        int            lat;
        logic [DW-1:0] snap_d;
        logic [1:0]    snap_b;
        bit            stable;

        hw_in[15*DW +: DW] = HW15;
        hw_in[0 +: DW]     = 32'hCAFE_0000;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_readies", 64'({awready, wready, arready}), 64'h7);
        check("rst_reg3", 64'(reg_out[3*DW +: DW]), 64'h0000_BEEF);
        check("rst_reg0", 64'(reg_out[0 +: DW]), 64'h0);
        check("rst_strobes", 64'({reg_wr_stb, reg_rd_stb}), 64'h0);
        do_read(16'h000C, d, resp, stb);
        check("rst_read3", 64'(d), 64'h0000_BEEF);
        $display("read  reg3 after reset: data=%h resp=%0d", d, resp);

        for (int i = 0; i < RC; i++) begin
            do_write(16'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF, resp, stb, lat);
            $display("write idx=%0d resp=%0d wr_stb=%h", i, resp, stb);
            check($sformatf("wr_resp_%0d", i), 64'(resp), (i == 15) ? 64'd2 : 64'd0);
            check($sformatf("wr_stb_%0d", i), 64'(stb), (i == 15) ? 64'd0 : 64'd1 << i);
        end
        for (int i = 0; i < RC; i++) begin
            do_read(16'(i * 4), d, resp, stb);
            $display("read  idx=%0d data=%h resp=%0d rd_stb=%h", i, d, resp, stb);
            check($sformatf("rd_data_%0d", i), 64'(d), (i == 15) ? 64'(HW15) : 64'(32'hA5A5_0000 + 32'(i)));
            check($sformatf("rd_resp_%0d", i), 64'(resp), 64'd0);
            check($sformatf("rd_stb_%0d", i), 64'(stb), 64'd1 << i);
        end
        check("ro_reg_out_zero", 64'(reg_out[15*DW +: DW]), 64'h0);

        // W leads AW by three cycles.
        awaddr = 16'h0024; wdata = 32'h0909_0909; wstrb = 4'hF;
        wvalid = 1'b1; tick(); wvalid = 1'b0;
        check("wfirst_wready_held", 64'(wready), 64'd0);
        tick(); tick();
        awvalid = 1'b1; tick(); awvalid = 1'b0;
        check("wfirst_no_bvalid_yet", 64'(bvalid), 64'd0);
        tick();
        check("wfirst_bvalid", 64'(bvalid), 64'd1);
        check("wfirst_stb", 64'(reg_wr_stb), 64'd1 << 9);
        tick();
        $display("skew write W-first idx=9 done");
        // AW leads W by three cycles.
        awaddr = 16'h0028; wdata = 32'h0A0A_0A0A;
        awvalid = 1'b1; tick(); awvalid = 1'b0;
        check("awfirst_awready_held", 64'(awready), 64'd0);
        tick(); tick();
        wvalid = 1'b1; tick(); wvalid = 1'b0;
        check("awfirst_no_bvalid_yet", 64'(bvalid), 64'd0);
        tick();
        check("awfirst_bvalid", 64'(bvalid), 64'd1);
        tick();
        $display("skew write AW-first idx=10 done");
        do_read(16'h0024, d, resp, stb);
        check("wfirst_readback", 64'(d), 64'h0909_0909);
        do_read(16'h0028, d, resp, stb);
        check("awfirst_readback", 64'(d), 64'h0A0A_0A0A);

        do_write(16'h0014, 32'hFFFF_FFFF, 4'hF, resp, stb, lat);
        do_write(16'h0014, 32'h1122_3344, 4'h5, resp, stb, lat);
        do_read(16'h0014, d, resp, stb);
        $display("strobe write idx=5 data=%h", d);
        check("strb_merge", 64'(d), 64'hFF22_FF44);

        do_write(16'h0040, 32'h1234_5678, 4'hF, resp, stb, lat);
        $display("write idx=16 resp=%0d", resp);
        check("decerr_bresp", 64'(resp), 64'd3);
        check("decerr_wr_stb", 64'(stb), 64'd0);
        do_read(16'h0040, d, resp, stb);
        $display("read  idx=16 data=%h resp=%0d", d, resp);
        check("decerr_rresp", 64'(resp), 64'd3);
        check("decerr_rdata", 64'(d), 64'd0);
        check("decerr_rd_stb", 64'(stb), 64'd0);

        do_write(16'h003C, 32'h0000_0001, 4'hF, resp, stb, lat);
        check("ro_bresp", 64'(resp), 64'd2);
        do_read(16'h003C, d, resp, stb);
        check("ro_read_hw_in", 64'(d), 64'(HW15));

        do_write(16'h001C, 32'hFFFF_FFFF, 4'h0, resp, stb, lat);
        $display("write idx=7 wstrb=0 resp=%0d wr_stb=%h", resp, stb);
        check("zero_strb_resp", 64'(resp), 64'd0);
        check("zero_strb_stb", 64'(stb), 64'd1 << 7);
        do_read(16'h001C, d, resp, stb);
        check("zero_strb_unchanged", 64'(d), 64'hA5A5_0007);

        // Read and write of reg 8 committing on the same edge.
        awaddr = 16'h0020; wdata = 32'hDEAD_0008; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 16'h0020; arvalid = 1'b1; tick(); arvalid = 1'b0;
        $display("same-cycle rw idx=8 rdata=%h bvalid=%0d", rdata, bvalid);
        check("rw_same_rdata_old", 64'(rdata), 64'hA5A5_0008);
        check("rw_same_bvalid", 64'(bvalid), 64'd1);
        check("rw_same_wr_stb", 64'(reg_wr_stb), 64'd1 << 8);
        check("rw_same_rd_stb", 64'(reg_rd_stb), 64'd1 << 8);
        tick();
        do_read(16'h0020, d, resp, stb);
        check("rw_same_new", 64'(d), 64'hDEAD_0008);

        // Backpressure on both response channels.
        bready = 1'b0; rready = 1'b0;
        awaddr = 16'h0008; wdata = 32'h1234_5678; wstrb = 4'hF;
        araddr = 16'h0010;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; tick();
        snap_d = rdata; snap_b = bresp;
        check("bp_bvalid", 64'(bvalid), 64'd1);
        check("bp_rvalid", 64'(rvalid), 64'd1);
        check("bp_rdata", 64'(snap_d), 64'hA5A5_0004);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!bvalid || !rvalid || bresp != snap_b || rdata != snap_d ||
                awready || wready || arready) stable = 1'b0;
        end
        $display("backpressure 10 cycles: stable=%0d", stable);
        check("bp_stable", 64'(stable), 64'd1);
        bready = 1'b1; rready = 1'b1; tick();
        check("bp_release", 64'({bvalid, rvalid}), 64'd0);
        do_read(16'h0008, d, resp, stb);
        check("bp_write_landed", 64'(d), 64'h1234_5678);

        // Reset while AW is held and rvalid is up.
        rready = 1'b0;
        awaddr = 16'h0000; araddr = 16'h0000;
        awvalid = 1'b1; arvalid = 1'b1; tick();
        awvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_aw_held", 64'(awready), 64'd0);
        check("pre_rst_rvalid", 64'(rvalid), 64'd1);
        rst_n = 1'b0; #1;
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check("mid_rst_readies", 64'({awready, wready, arready}), 64'h7);
        check("mid_rst_reg0", 64'(reg_out[0 +: DW]), 64'h0);
        check("mid_rst_reg3", 64'(reg_out[3*DW +: DW]), 64'h0000_BEEF);
        tick();
        rst_n = 1'b1; rready = 1'b1;
        tick();
        do_write(16'h0004, 32'h0BAD_F00D, 4'hF, resp, stb, lat);
        $display("post-reset write idx=1 resp=%0d lat=%0d", resp, lat);
        check("post_rst_bresp", 64'(resp), 64'd0);
        check("post_rst_latency", 64'(lat), 64'd1);
        do_read(16'h0004, d, resp, stb);
        check("post_rst_readback", 64'(d), 64'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
